memory_round_ctrl: RTL and testbench
====================================

# memory_round_ctrl

Parametrised round controller for the memorization game. It latches an N-digit hex target from the random source and shows it for a level-dependent window. It then collects keypad digits into an entry buffer, compares the full word, and tracks level, lives and game-over. It sits between `clockdiv`/`randnum`/the keyboard loader and `display`, replacing the fixed 4-digit single-round display-phase logic in the game top.

## Interface
Parameters:
- `DIGITS`, 4: hex digits per target (1..8); word width `W = 4*DIGITS`.
- `DISPLAY_CYCLES`, 500000000: show window at level 1, in `clk` cycles.
- `DISPLAY_STEP`, 50000000: show-window reduction per level; floor is `DISPLAY_STEP`.
- `RESULT_CYCLES`, 100000000: feedback hold after each check.
- `TIMEOUT_CYCLES`, 1000000000: entry timeout; only used with `GAME_TIMEOUT_EN`.
- `MAX_LEVEL`, 8: a correct answer at this level wins the game.
- `LIVES`, 3: wrong answers allowed before game over (1..3).

Ports:
- `clk` in 1: system clock. One clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins or restarts a game.
- `rand_in` in W: random word, sampled in LOAD.
- `key_valid` in 1: one-cycle strobe of a debounced key.
- `key_code` in 4: hex digit qualified by `key_valid`.
- `key_clear` in 1: one-cycle pulse; empties the entry buffer.
- `target` out W: latched target word.
- `entry` out W: entry buffer, right-aligned.
- `entry_count` out clog2(DIGITS+1): digits entered so far.
- `show_target` out 1: high only in SHOW.
- `phase` out 3: current state encoding.
- `level` out clog2(MAX_LEVEL+1): current level, starting at 1.
- `lives` out 2: remaining lives.
- `correct` out 1: one-cycle pulse on a match.
- `wrong` out 1: one-cycle pulse on a mismatch or timeout.
- `game_over` out 1: high in OVER.
- `won` out 1: high in OVER when the game was won.

## Operation
- States: IDLE(0), LOAD(1), SHOW(2), ENTRY(3), CHECK(4), RESULT(5), OVER(6).
- IDLE: `start` → LOAD.
- LOAD, one cycle:
  - `target <= rand_in`; entry and count cleared.
  - Timer loaded with `max(DISPLAY_CYCLES - (level-1)*DISPLAY_STEP, DISPLAY_STEP)`, computed in 32-bit unsigned arithmetic with no underflow.
  - → SHOW.
- SHOW: `show_target=1`; keys ignored; timer expiry → ENTRY.
- ENTRY: on `key_valid`, `entry <= {entry[W-5:0], key_code}` and count increments.
  - Keys are ignored once count equals DIGITS.
  - `key_clear` zeroes entry and count. When `key_clear` and `key_valid` arrive in the same cycle, clear wins.
  - Count reaching DIGITS → CHECK on the next cycle.
- CHECK, one cycle: full-word compare of `entry` against `target` → RESULT.
  - Match: level increments. At `MAX_LEVEL`, the level is not incremented and `won` is set.
  - Mismatch: lives decrement.
- RESULT: hold `RESULT_CYCLES`, then:
  - → OVER if `won`, or if `lives == 0`.
  - Otherwise → LOAD, always with a fresh target; the level is unchanged after a miss.
- OVER: `game_over=1`. `start` → LOAD with level 1, lives `LIVES`, `won` 0.
- `start` is ignored outside IDLE and OVER.
- Reset values: target 0, entry 0, entry_count 0, show_target 0, phase IDLE, level 1, lives `LIVES`, correct 0, wrong 0, game_over 0, won 0.
- `rst` mid-round aborts immediately to these values.

## Timing
- `start` at cycle t → LOAD at t+1 → SHOW at t+2.
- SHOW lasts exactly the loaded count; ENTRY is entered the cycle after the last SHOW cycle.
- The last digit is accepted at cycle k → CHECK at k+1 → RESULT at k+2.
- `correct`/`wrong` are registered and high only in the first RESULT cycle. `level`/`lives` update in that same cycle.
- RESULT lasts exactly `RESULT_CYCLES`, then LOAD.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `GAME_TIMEOUT_EN` defined:
  - The ENTRY timer loads `TIMEOUT_CYCLES` on ENTRY entry and on every accepted key.
  - Expiry → RESULT with a `wrong` pulse and a life decrement, identical to a mismatch.
- `GAME_TIMEOUT_EN` undefined: ENTRY waits indefinitely and no timeout logic is synthesised.

## Structure
- Package `game_pkg`:
  - State enum with the encodings above.
  - `DIG_W = 4`.
  - Level/lives width functions.
- Sub-module `game_timer`: loadable 32-bit down-counter with `load`, `value` and a `done` pulse. A single instance is shared by SHOW, RESULT and the timeout.

## Test plan
Bench parameters: DIGITS=4, DISPLAY_CYCLES=10, DISPLAY_STEP=2, RESULT_CYCLES=3, LIVES=2, MAX_LEVEL=3, TIMEOUT_CYCLES=20.
- Reset, then `start` with `rand_in=16'hA3F1` → target A3F1; `show_target` high for exactly 10 cycles; phase goes 1→2→3.
- Keys A,3,F,1 in ENTRY → `correct` pulse for 1 cycle; level 2; next SHOW lasts 8 cycles.
- Keys A,3,F,2 → `wrong` pulse; lives 1. A second miss → lives 0 and OVER after 3 RESULT cycles with `game_over=1`, `won=0`.
- Keys A,3, then `key_clear` with a simultaneous `key_valid` → entry 0, count 0. Keys pressed during SHOW → entry unchanged.
- Three correct rounds → OVER with `won=1`, level 3. `start` → level 1, lives 2. Asserting `rst` during SHOW → all reset values at once.
- With `GAME_TIMEOUT_EN`: no key for 20 cycles → `wrong` pulse and lives decremented. Without it: no transition after 1000 idle cycles.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the memorization-game round controller.
package game_pkg;

    localparam int DIG_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHOW   = 3'd2,
        ST_ENTRY  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_RESULT = 3'd5,
        ST_OVER   = 3'd6
    } state_e;

    // Width of the level counter, which must hold 1..max_level.
    function automatic int level_w(input int max_level);
        return (max_level < 2) ? 1 : $clog2(max_level + 1);
    endfunction

    // Width of the lives counter; LIVES is 1..3 so two bits always suffice.
    function automatic int lives_w(input int lives);
        return (lives < 4) ? 2 : $clog2(lives + 1);
    endfunction

    // Show window for a level: shrinks by ds per level, never below ds,
    // evaluated wide so the subtraction can never wrap.
    function automatic logic [31:0] show_len(input logic [31:0] lvl,
                                             input logic [31:0] dc,
                                             input logic [31:0] ds);
        logic [63:0] red;
        logic [31:0] rem;
        red = 64'(lvl - 32'd1) * 64'(ds);
        if (red >= 64'(dc)) return ds;
        rem = dc - red[31:0];
        return (rem < ds) ? ds : rem;
    endfunction

endpackage

// File: rtl/game_timer.sv
// Loadable 32-bit down-counter; done pulses on the last counted cycle.
module game_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    output logic        done
);
    logic [31:0] cnt_q;

    // Count down to zero after a load, then hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               cnt_q <= '0;
        else if (load)         cnt_q <= value;
        else if (cnt_q != '0)  cnt_q <= cnt_q - 32'd1;
    end

    // A count of N loaded at edge t covers cycles t+1..t+N; the last is value 1.
    assign done = (cnt_q == 32'd1);
endmodule

// File: rtl/memory_round_ctrl.sv
// Round controller for the memorization game: latch a target, show it for a
// level-dependent window, collect keypad digits, score, track level/lives.
// Optional entry timeout is built when GAME_TIMEOUT_EN is defined.
module memory_round_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned DISPLAY_CYCLES = 500000000,
    parameter int unsigned DISPLAY_STEP   = 50000000,
    parameter int unsigned RESULT_CYCLES  = 100000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000000,
    parameter int unsigned MAX_LEVEL      = 8,
    parameter int unsigned LIVES          = 3,
    localparam int W  = DIG_W * DIGITS,
    localparam int CW = $clog2(DIGITS + 1),
    localparam int LW = level_w(MAX_LEVEL),
    localparam int VW = lives_w(LIVES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  rand_in,
    input  logic          key_valid,
    input  logic [3:0]    key_code,
    input  logic          key_clear,
    output logic [W-1:0]  target,
    output logic [W-1:0]  entry,
    output logic [CW-1:0] entry_count,
    output logic          show_target,
    output logic [2:0]    phase,
    output logic [LW-1:0] level,
    output logic [VW-1:0] lives,
    output logic          correct,
    output logic          wrong,
    output logic          game_over,
    output logic          won
);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);
    localparam logic [LW-1:0] LVL_MAX  = LW'(MAX_LEVEL);
    localparam logic [VW-1:0] LIV_INIT = VW'(LIVES);

    state_e        state_q, state_d;
    logic [W-1:0]  target_q, target_d;
    logic [W-1:0]  entry_q, entry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] level_q, level_d;
    logic [VW-1:0] lives_q, lives_d;
    logic          won_q, won_d;
    logic          correct_q, correct_d;
    logic          wrong_q, wrong_d;
    logic          show_q, over_q;

    logic          tmr_load, tmr_done, accept;
    logic [31:0]   tmr_val;

    // One timer serves the show window, the result hold and the entry timeout.
    game_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_val),
        .done  (tmr_done)
    );

    assign accept = key_valid && !key_clear && (cnt_q < CNT_FULL);

    // Next-state, datapath updates and timer control.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        lives_d   = lives_q;
        won_d     = won_q;
        correct_d = 1'b0;
        wrong_d   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                target_d = rand_in;
                entry_d  = '0;
                cnt_d    = '0;
                tmr_load = 1'b1;
                tmr_val  = show_len(32'(level_q), DISPLAY_CYCLES, DISPLAY_STEP);
                state_d  = ST_SHOW;
            end
            ST_SHOW: if (tmr_done) begin
                state_d = ST_ENTRY;
`ifdef GAME_TIMEOUT_EN
                tmr_load = 1'b1;
                tmr_val  = TIMEOUT_CYCLES;
`endif
            end
            ST_ENTRY: begin
                if (key_clear) begin
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    entry_d = W'({entry_q, key_code});
                    cnt_d   = cnt_q + CW'(1);
                    // Move on with the last digit so CHECK follows immediately.
                    if (cnt_q == CNT_LAST) state_d = ST_CHECK;
`ifdef GAME_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_CYCLES;
`endif
                end
`ifdef GAME_TIMEOUT_EN
                // A timeout scores exactly like a wrong answer.
                if (!accept && tmr_done) begin
                    state_d  = ST_RESULT;
                    wrong_d  = 1'b1;
                    lives_d  = (lives_q != '0) ? lives_q - VW'(1) : lives_q;
                    tmr_load = 1'b1;
                    tmr_val  = RESULT_CYCLES;
                end
`endif
            end
            ST_CHECK: begin
                tmr_load = 1'b1;
                tmr_val  = RESULT_CYCLES;
                state_d  = ST_RESULT;
                if (entry_q == target_q) begin
                    correct_d = 1'b1;
                    if (level_q == LVL_MAX) won_d   = 1'b1;
                    else                    level_d = level_q + LW'(1);
                end else begin
                    wrong_d = 1'b1;
                    lives_d = (lives_q != '0) ? lives_q - VW'(1) : lives_q;
                end
            end
            ST_RESULT: if (tmr_done) begin
                state_d = (won_q || lives_q == '0) ? ST_OVER : ST_LOAD;
            end
            ST_OVER: if (start) begin
                state_d = ST_LOAD;
                level_d = LW'(1);
                lives_d = LIV_INIT;
                won_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; status flags follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            target_q  <= '0;
            entry_q   <= '0;
            cnt_q     <= '0;
            level_q   <= LW'(1);
            lives_q   <= LIV_INIT;
            won_q     <= 1'b0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            show_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            entry_q   <= entry_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            lives_q   <= lives_d;
            won_q     <= won_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            show_q    <= (state_d == ST_SHOW);
            over_q    <= (state_d == ST_OVER);
        end
    end

    assign target      = target_q;
    assign entry       = entry_q;
    assign entry_count = cnt_q;
    assign show_target = show_q;
    assign phase       = state_q;
    assign level       = level_q;
    assign lives       = lives_q;
    assign correct     = correct_q;
    assign wrong       = wrong_q;
    assign game_over   = over_q;
    assign won         = won_q;
endmodule

// File: tb/tb_memory_round_ctrl.sv
// Directed bench for memory_round_ctrl with short, hand-computed windows.
module tb_memory_round_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, key_valid, key_clear;
    logic [15:0] rand_in;
    logic [3:0]  key_code;
    logic [15:0] target, entry;
    logic [2:0]  entry_count, phase;
    logic [1:0]  level, lives;
    logic        show_target, correct, wrong, game_over, won;

    int checks = 0;
    int failures = 0;

    memory_round_ctrl #(
        .DIGITS(4), .DISPLAY_CYCLES(10), .DISPLAY_STEP(2), .RESULT_CYCLES(3),
        .TIMEOUT_CYCLES(20), .MAX_LEVEL(3), .LIVES(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rand_in(rand_in),
        .key_valid(key_valid), .key_code(key_code), .key_clear(key_clear),
        .target(target), .entry(entry), .entry_count(entry_count),
        .show_target(show_target), .phase(phase), .level(level), .lives(lives),
        .correct(correct), .wrong(wrong), .game_over(game_over), .won(won)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1; key_code = c;
        tick();
        key_valid = 1'b0;
    endtask

    // Called while sampling LOAD; measures SHOW and presses a stray key in it.
    task automatic do_show(input int exp_len);
        int n;
        tick();
        chk("show_phase", 32'(phase), 32'd2);
        n = 0;
        while (show_target && n < 100) begin
            n++;
            key_valid = (n == 3); key_code = 4'h7;
            tick();
        end
        key_valid = 1'b0;
        chk("show_len", 32'(n), 32'(exp_len));
        chk("entry_phase", 32'(phase), 32'd3);
        chk("show_key_ignored", 32'({entry, 13'd0, entry_count}), 32'd0);
    endtask

    task automatic enter_word(input logic [15:0] w);
        press(w[15:12]); press(w[11:8]); press(w[7:4]); press(w[3:0]);
        chk("check_phase", 32'(phase), 32'd4);
    endtask

    task automatic result(input logic c, input logic wr, input int lv, input int li,
                          input int nxt);
        tick();
        chk("res_phase", 32'(phase), 32'd5);
        chk("res_correct", 32'(correct), 32'(c));
        chk("res_wrong", 32'(wrong), 32'(wr));
        chk("res_level", 32'(level), 32'(lv));
        chk("res_lives", 32'(lives), 32'(li));
        tick();
        chk("pulse_len", 32'({correct, wrong}), 32'd0);
        tick();
        chk("res_hold", 32'(phase), 32'd5);
        tick();
        chk("res_next", 32'(phase), 32'(nxt));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key_valid = 1'b0; key_clear = 1'b0;
        key_code = 4'h0; rand_in = 16'h0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_level", 32'(level), 32'd1);
        chk("rst_lives", 32'(lives), 32'd2);
        chk("rst_target", 32'(target), 32'd0);
        chk("rst_flags", 32'({show_target, correct, wrong, game_over, won}), 32'd0);

        // Round 1: correct at level 1.
        start = 1'b1; rand_in = 16'hA3F1;
        tick();
        start = 1'b0;
        chk("load_phase", 32'(phase), 32'd1);
        do_show(10);
        chk("target", 32'(target), 32'hA3F1);
        enter_word(16'hA3F1);
        result(1'b1, 1'b0, 2, 2, 1);

        // Round 2: miss at level 2 (window 8).
        do_show(8);
        enter_word(16'hA3F2);
        result(1'b0, 1'b1, 2, 1, 1);

        // Round 3: clear beats a simultaneous key, then a second miss ends it.
        do_show(8);
        press(4'hA); press(4'h3);
        chk("partial_entry", 32'(entry), 32'h00A3);
        chk("partial_cnt", 32'(entry_count), 32'd2);
        key_clear = 1'b1; key_valid = 1'b1; key_code = 4'hF;
        tick();
        key_clear = 1'b0; key_valid = 1'b0;
        chk("clear_entry", 32'(entry), 32'd0);
        chk("clear_cnt", 32'(entry_count), 32'd0);
        chk("clear_phase", 32'(phase), 32'd3);
        enter_word(16'hA3F0);
        result(1'b0, 1'b1, 2, 0, 6);
        chk("lost_over", 32'({game_over, won}), 32'b10);

        // New game from OVER, then win three rounds.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_phase", 32'(phase), 32'd1);
        chk("restart_level", 32'(level), 32'd1);
        chk("restart_lives", 32'(lives), 32'd2);
        chk("restart_flags", 32'({game_over, won}), 32'd0);
        do_show(10);
        enter_word(16'hA3F1);
        result(1'b1, 1'b0, 2, 2, 1);
        do_show(8);
        enter_word(16'hA3F1);
        result(1'b1, 1'b0, 3, 2, 1);
        do_show(6);
        enter_word(16'hA3F1);
        result(1'b1, 1'b0, 3, 2, 6);
        chk("won_over", 32'({game_over, won}), 32'b11);
        chk("won_level", 32'(level), 32'd3);

        // Reset in the middle of SHOW.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_show", 32'(show_target), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_target", 32'(target), 32'd0);
        chk("arst_level", 32'(level), 32'd1);
        chk("arst_lives", 32'(lives), 32'd2);
        chk("arst_flags", 32'({show_target, correct, wrong, game_over, won}), 32'd0);
        chk("arst_entry", 32'({entry, 13'd0, entry_count}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Idle in ENTRY.
        start = 1'b1; rand_in = 16'h5C07;
        tick();
        start = 1'b0;
        do_show(10);
`ifdef GAME_TIMEOUT_EN
        repeat (19) tick();
        chk("to_wait", 32'(phase), 32'd3);
        tick();
        chk("to_phase", 32'(phase), 32'd5);
        chk("to_wrong", 32'(wrong), 32'd1);
        chk("to_lives", 32'(lives), 32'd1);
`else
        repeat (1000) tick();
        chk("no_to_phase", 32'(phase), 32'd3);
        chk("no_to_flags", 32'({correct, wrong}), 32'd0);
        chk("no_to_lives", 32'(lives), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
